// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
package mult_pkg;

    // Default operand width; HI and LO are each this wide.
    localparam int WIDTH = 32;

    // One shift-add step per operand bit.
    localparam int ITER = WIDTH;

    // Iteration counter must be able to hold the value ITER itself.
    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mult_datapath.sv
// Shift-add datapath: operand magnitudes, 2*WIDTH accumulator, signed fix-up.
module mult_datapath #(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               sign;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               sign_in;

    // Operand magnitudes and result sign; -0x80..0 wraps to itself, which
    // read as unsigned is exactly 2^(WIDTH-1).
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        mag_a   = a;
        mag_b   = b;
        sign_in = 1'b0;
        if (is_signed) begin
            if (a[WIDTH-1]) mag_a = -a;
            if (b[WIDTH-1]) mag_b = -b;
            sign_in = a[WIDTH-1] ^ b[WIDTH-1];
        end
    end

    // Accumulator and shifting operands: load on start, one step per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these are plain flops rather than a RAM, so they can and do take the async reset.
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            sign   <= 1'b0;
        end else if (load) begin
            // NOTE: non-blocking assignments make every register see pre-edge values.
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            sign   <= sign_in;
        end else if (step) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
        end
    end

    // Final conditional negate of the unsigned magnitude product.
    always_comb begin
        product = sign ? -acc : acc;
    end

endmodule

// File: rtl/mult_unit.sv
// Multi-cycle multiply unit with HI/LO result registers and mthi/mtlo writes.
module mult_unit #(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import mult_pkg::*;

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      count;
    logic               load;
    logic               step;
    logic               finish;
    logic [2*WIDTH-1:0] product;

    mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .product   (product)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and datapath controls: accept start only in IDLE, WIDTH steps, then finish.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (count == LAST) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    step = 1'b1;
                end
            end
        endcase
    end

    // Iteration counter: cleared on start, advanced once per shift-add step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    count <= '0;
        else if (load) count <= '0;
        else if (step) count <= count + CW'(1);
    end

    // HI/LO: product load on finish; mthi/mtlo writes honoured only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (finish) begin
            hi <= product[2*WIDTH-1:WIDTH];
            lo <= product[WIDTH-1:0];
        end else if (state == IDLE) begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
        end
    end

    // done pulses for the single cycle in which the new HI/LO are visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b0;
        else        done <= finish;
    end

    assign busy = (state == RUN);

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand width; HI and LO are each WIDTH bits.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request a multiply of a and b.
REQ-006 Port: is_signed  input  1  1 means two's-complement operands; 0 means unsigned.
REQ-007 Port: a  input  WIDTH  multiplicand.
REQ-008 Port: b  input  WIDTH  multiplier.
REQ-009 Port: wr_hi  input  1  write wr_data into HI (mthi).
REQ-010 Port: wr_lo  input  1  write wr_data into LO (mtlo).
REQ-011 Port: wr_data  input  WIDTH  data for HI/LO writes.
REQ-012 Port: busy  output  1  multiply in progress.
REQ-013 Port: done  output  1  one-cycle pulse when the HI/LO product is valid.
REQ-014 Port: hi  output  WIDTH  upper product register; feeds the 32-bit 2:1 result mux.
REQ-015 Port: lo  output  WIDTH  lower product register; feeds the 32-bit 2:1 result mux.

Function
REQ-016 FSM SHALL have states IDLE and RUN.
REQ-017 In IDLE, start=1 at edge E0 SHALL latch |a|, |b|, the result sign (a[31]^b[31] when is_signed, else 0) and iteration count 0; the FSM goes to RUN and busy=1 after E0.
REQ-018 RUN SHALL perform one unsigned shift-add step per cycle on the magnitudes, for exactly WIDTH steps (edges E1..E32).
REQ-019 At edge E33, HI:LO SHALL load the 2*WIDTH product, negated when the result sign=1; in the same edge busy=0, done=1 and state=IDLE.
REQ-020 done SHALL be high for exactly one cycle, coincident with new hi/lo values; latency from the start edge to done SHALL be 33 cycles.
REQ-021 The magnitude of 0x80000000 SHALL be treated as unsigned 2^31, so the signed product is exact for all operands.
REQ-022 start SHALL be ignored while busy=1; the back-to-back earliest accepted start is the cycle done=1.
REQ-023 wr_hi/wr_lo SHALL update the selected register at the next edge only while idle; they SHALL be ignored while busy=1.
REQ-024 If start and wr_hi/wr_lo occur together in IDLE, the write SHALL take effect; the later product SHALL overwrite it at E33.
REQ-025 hi/lo SHALL hold their value between updates; a/b SHALL not need to be held after E0.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, count=0 and clear the accumulator.
REQ-027 Reset during RUN SHALL abort the operation: no done pulse and no HI/LO write after release.
REQ-028 After rst_n rises, the first start SHALL be accepted at the first clock edge.

Structure
REQ-029 Shared package mult_pkg SHALL hold WIDTH, ITER=WIDTH, the state typedef {IDLE, RUN} and the counter width $clog2(ITER+1).
REQ-030 Sub-module mult_datapath (64-bit accumulator, shift-add, final conditional negate) SHALL be used; the FSM, counter and HI/LO registers SHALL stay in mult_unit.

Verification
REQ-031 Unsigned 3*5: hi=0, lo=15; done exactly 33 cycles after the start edge; busy high for 33 cycles.
REQ-032 0xFFFFFFFF*0xFFFFFFFF: with is_signed=1, hi=0 and lo=1; with is_signed=0, hi=0xFFFFFFFE and lo=0x00000001.
REQ-033 Signed -3*7: hi=0xFFFFFFFF, lo=0xFFFFFFEB. Signed 0x80000000*0x80000000: hi=0x40000000, lo=0.
REQ-034 Ignore-while-busy case: start 2*2, then at cycle 5 pulse start with 9*9 and pulse wr_hi with 0xDEADBEEF; result SHALL be hi=0, lo=4 and only one done pulse.
REQ-035 Reset abort: start 6*7, assert rst_n=0 at cycle 10, release; hi=lo=0, busy=0, no done. A new 6*7 SHALL then give lo=42.
REQ-036 Idle writes: wr_hi with 0x12345678 then wr_lo with 0x9ABCDEF0; each SHALL be visible the next cycle with the other register unchanged.
